pingpong_operand_buffer: RTL and testbench
==========================================

# pingpong_operand_buffer

Double-banked (ping-pong) operand buffer for the TensorCore datapath: a producer fills one bank while the consumer reads the other, with explicit commit/release handshakes per bank. It generalises the single-bank operand store:
- parametrised width and depth;
- byte-masked writes;
- registered reads with a valid strobe;
- per-bank full/empty tracking;
- sticky protocol-error flags.

It sits between the operand loader and the MAC array's operand fetch.

## Interface
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8
- DEPTH, 64, words per bank; must be a power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), word address width within a bank
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- wr_en  input  1  write request to current write bank
- wr_addr  input  ADDR_WIDTH  write word address
- wr_data  input  DATA_WIDTH  write data
- wr_mask  input  DATA_WIDTH/8  byte enables, bit i covers byte i
- wr_commit  input  1  mark current write bank full and advance
- wr_ready  output  1  current write bank is not full
- rd_en  input  1  read request from current read bank
- rd_addr  input  ADDR_WIDTH  read word address
- rd_release  input  1  free current read bank and advance
- rd_ready  output  1  current read bank is full (readable)
- rd_data  output  DATA_WIDTH  registered read data
- rd_valid  output  1  rd_data valid this cycle
- bank_full  output  2  full flag per bank
- err_wr_drop  output  1  sticky: write or commit attempted while !wr_ready
- err_rd_empty  output  1  sticky: read or release attempted while !rd_ready

## Operation
- **State.**
  - Storage: two banks of DEPTH×DATA_WIDTH.
  - Pointers: wr_bank and rd_bank, one bit each.
  - Flags: full[1:0].
- **Outputs.**
  - wr_ready = !full[wr_bank].
  - rd_ready = full[rd_bank].
  - bank_full = full.
- **Write.** A write is accepted when wr_en && wr_ready. Each byte i with wr_mask[i]=1 is written to bank wr_bank at wr_addr. Unmasked bytes keep their old value.
- **Commit.** A commit is accepted when wr_commit && wr_ready. It sets full[wr_bank] and toggles wr_bank. A write and a commit in the same cycle are both applied: the write lands in the bank being committed.
- **Read.** A read is accepted when rd_en && rd_ready. rd_data takes bank rd_bank at rd_addr on the next cycle, and rd_valid=1 that cycle. A read that is not accepted gives rd_valid=0 next cycle and leaves rd_data holding its last value.
- **Release.** A release is accepted when rd_release && rd_ready. It clears full[rd_bank] and toggles rd_bank. A read and a release in the same cycle: the read returns data from the bank being released.
- **No commit/release collision.** A commit and a release can never act on the same bank in one cycle. A commit needs its bank not full; a release needs its bank full. Two accepted events on different banks are both applied.
- **Errors.**
  - err_wr_drop sets on (wr_en || wr_commit) && !wr_ready. The dropped write or commit has no other effect.
  - err_rd_empty sets on (rd_en || rd_release) && !rd_ready. The dropped read gives rd_valid=0 next cycle.
  - Both flags clear only on reset.
- **Address decode.** No out-of-range case exists: DEPTH is a power of two, so every ADDR_WIDTH address is valid.
- **Reset (rst_n=0 at a clock edge).**
  - wr_bank=0, rd_bank=0, full=2'b00, rd_valid=0, rd_data=0, both error flags 0.
  - Resulting outputs: wr_ready=1, rd_ready=0, bank_full=0.
  - Memory contents are not cleared.
  - Reset mid-fill or mid-read discards all bank ownership. Inputs are ignored during the reset cycle.

## Timing
- Write to storage: visible to a read issued in the cycle after the write edge.
- Read latency: 1 cycle from accepted rd_en to rd_valid/rd_data.
- Commit to rd_ready:
  - If rd_bank is the committed bank, rd_ready rises the cycle after the commit edge.
  - Otherwise it rises when the consumer releases the other bank.
- Release to wr_ready: if the writer is stalled on the released bank, wr_ready rises the cycle after the release edge.
- Steady state: the writer fills bank A while the reader drains bank B, with no bubbles at commit/release boundaries.
- All outputs are registers or functions of registered state only. There is no combinational input-to-output path.

## Test plan
- **Reset values.** Hold rst_n=0 for 2 cycles with random inputs -> wr_ready=1, rd_ready=0, bank_full=0, rd_valid=0, rd_data=0, both err flags 0.
- **Fill, commit, read back.**
  - Write bank0 addr k = 64'h1000+k for k=0..63 with mask all 1s, then wr_commit.
  - Expect bank_full=2'b01 and rd_ready=1.
  - rd_en at addr 5 -> next cycle rd_valid=1, rd_data=64'h1005.
- **Byte mask.** Write 64'hFFFF_FFFF_FFFF_FFFF to addr 3, then write 64'h0 to addr 3 with wr_mask=8'h0F, commit, read -> rd_data=64'hFFFF_FFFF_0000_0000.
- **Ping-pong overlap.**
  - Commit bank0 and fill bank1 while reading bank0.
  - Commit bank1 with bank0 still full -> wr_ready=0.
  - rd_release -> wr_ready=1 the next cycle and rd_ready stays 1 (now bank1).
  - Reads return bank1 data.
- **Protocol errors.**
  - wr_en with both banks full -> err_wr_drop=1 and memory unchanged (verified by readback).
  - rd_en with bank_full=0 -> err_rd_empty=1 and rd_valid=0.
  - Both flags stay set until rst_n=0.
- **Simultaneous events and mid-operation reset.**
  - Same cycle: rd_en plus rd_release on bank0, and wr_en plus wr_commit on bank1 -> rd_data is bank0 data, bank_full=2'b10, wr_bank=0, rd_bank=1.
  - Then assert rst_n=0 mid-fill -> bank_full=0 and rd_ready=0 on the next cycle.

Source files
------------

// File: rtl/pingpong_operand_buffer.sv
// Ping-pong operand buffer: producer fills one bank while the consumer
// drains the other, with per-bank commit/release ownership handoff.
module pingpong_operand_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic                    wr_commit,
  output logic                    wr_ready,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_release,
  output logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [1:0]              bank_full,
  output logic                    err_wr_drop,
  output logic                    err_rd_empty
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic wr_acc;
  logic cm_acc;
  logic rd_acc;
  logic rl_acc;

  logic [ADDR_WIDTH:0] wr_idx;
  logic [ADDR_WIDTH:0] rd_idx;

  assign wr_ready  = !full[wr_bank];
  assign rd_ready  = full[rd_bank];
  assign bank_full = full;

  assign wr_acc = wr_en && wr_ready;
  assign cm_acc = wr_commit && wr_ready;
  assign rd_acc = rd_en && rd_ready;
  assign rl_acc = rd_release && rd_ready;

  assign wr_idx = {wr_bank, wr_addr};
  assign rd_idx = {rd_bank, rd_addr};

  // Commit and release always target different banks, so both can apply.
  always_comb begin
    full_nxt = full;
    if (cm_acc) full_nxt[wr_bank] = 1'b1;
    if (rl_acc) full_nxt[rd_bank] = 1'b0;
  end

  // Storage is not reset; only bank ownership is.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_mask[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      full         <= 2'b00;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err_wr_drop  <= 1'b0;
      err_rd_empty <= 1'b0;
    end else begin
      full     <= full_nxt;
      rd_valid <= rd_acc;
      if (cm_acc) wr_bank <= ~wr_bank;
      if (rl_acc) rd_bank <= ~rd_bank;
      if (rd_acc) rd_data <= mem[rd_idx];
      if ((wr_en || wr_commit) && !wr_ready) err_wr_drop <= 1'b1;
      if ((rd_en || rd_release) && !rd_ready) err_rd_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_operand_buffer.sv
// Bench for pingpong_operand_buffer: bank-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_pingpong_operand_buffer;

  localparam int DW = 64;
  localparam int D  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_mask = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_release = 1'b0;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    bank_full;
  logic          err_wr_drop;
  logic          err_rd_empty;

  always #5 clk = ~clk;

  pingpong_operand_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_commit(wr_commit), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .bank_full(bank_full), .err_wr_drop(err_wr_drop),
    .err_rd_empty(err_rd_empty)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: banks as arrays, ownership as two pointers + flags.
  logic [DW-1:0] m_mem [2][D];
  bit       m_wb, m_rb;
  bit [1:0] m_full;
  bit       m_valid;
  logic [DW-1:0] m_data = '0;
  bit       m_ewr, m_erd;
  bit       w_ok, r_ok, cb, rb;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wb = 0; m_rb = 0; m_full = 0; m_valid = 0;
      m_data = '0; m_ewr = 0; m_erd = 0;
    end else begin
      w_ok = !m_full[m_wb];
      r_ok = m_full[m_rb];
      cb = m_wb;
      rb = m_rb;
      if ((wr_en || wr_commit) && !w_ok) m_ewr = 1;
      if ((rd_en || rd_release) && !r_ok) m_erd = 1;
      m_valid = rd_en && r_ok;
      if (m_valid) m_data = m_mem[rb][rd_addr];
      if (wr_en && w_ok)
        for (int b = 0; b < 8; b++)
          if (wr_mask[b]) m_mem[cb][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
      if (wr_commit && w_ok) begin m_full[cb] = 1; m_wb = !cb; end
      if (rd_release && r_ok) begin m_full[rb] = 0; m_rb = !rb; end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_ready", 64'(wr_ready), 64'(!m_full[m_wb]));
      chk("rd_ready", 64'(rd_ready), 64'(m_full[m_rb]));
      chk("bank_full", 64'(bank_full), 64'(m_full));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_data", rd_data, m_data);
      chk("err_wr_drop", 64'(err_wr_drop), 64'(m_ewr));
      chk("err_rd_empty", 64'(err_rd_empty), 64'(m_erd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    wr_mask = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [7:0] m);
    wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
    cyc();
    idle();
  endtask

  task automatic commit();
    wr_commit = 1;
    cyc();
    idle();
  endtask

  task automatic release_bank();
    rd_release = 1;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1; rd_addr = a;
    cyc();
    idle();
  endtask

  initial begin
    // reset with random inputs
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'($urandom); wr_commit = 1'($urandom);
      rd_en = 1'($urandom); rd_release = 1'($urandom);
      wr_addr = AW'($urandom); rd_addr = AW'($urandom);
      wr_data = {$urandom, $urandom}; wr_mask = 8'($urandom);
      cyc();
    end
    idle();
    rst_n = 1;
    chk_on = 1;
    chk("rst wr_ready", 64'(wr_ready), 64'd1);
    chk("rst rd_ready", 64'(rd_ready), 64'd0);
    chk("rst bank_full", 64'(bank_full), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst rd_data", rd_data, 64'd0);
    chk("rst errs", 64'({err_wr_drop, err_rd_empty}), 64'd0);

    // fill bank0, commit, read back
    for (int k = 0; k < D; k++) wr(AW'(k), 64'h1000 + 64'(k), 8'hFF);
    commit();
    chk("commit0 bank_full", 64'(bank_full), 64'b01);
    chk("commit0 rd_ready", 64'(rd_ready), 64'd1);
    rd(6'd5);
    chk("rd5 valid", 64'(rd_valid), 64'd1);
    chk("rd5 data", rd_data, 64'h1005);

    // fill bank1 (byte mask) while reading bank0
    wr(6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd(6'd63);
    chk("rd63 data", rd_data, 64'h103F);
    wr(6'd3, 64'h0, 8'h0F);
    wr(6'd10, 64'hA5A5_0000_1234_5678, 8'hFF);
    commit();
    chk("both full wr_ready", 64'(wr_ready), 64'd0);
    chk("both full bank_full", 64'(bank_full), 64'b11);

    // dropped write while both full
    wr(6'd5, 64'hDEAD_BEEF, 8'hFF);
    chk("drop err_wr_drop", 64'(err_wr_drop), 64'd1);
    rd(6'd5);
    chk("drop mem intact", rd_data, 64'h1005);

    // release bank0: writer unstalls, reader moves to bank1
    release_bank();
    chk("rel wr_ready", 64'(wr_ready), 64'd1);
    chk("rel rd_ready", 64'(rd_ready), 64'd1);
    chk("rel bank_full", 64'(bank_full), 64'b10);
    rd(6'd3);
    chk("mask data", rd_data, 64'hFFFF_FFFF_0000_0000);
    rd(6'd10);
    chk("bank1 data", rd_data, 64'hA5A5_0000_1234_5678);
    release_bank();

    // read with nothing full
    rd(6'd0);
    chk("empty rd_valid", 64'(rd_valid), 64'd0);
    chk("empty err_rd_empty", 64'(err_rd_empty), 64'd1);
    chk("sticky err_wr_drop", 64'(err_wr_drop), 64'd1);

    // simultaneous read+release on bank0 and write+commit on bank1
    wr(6'd7, 64'h7777, 8'hFF);
    commit();
    rd_en = 1; rd_addr = 6'd7; rd_release = 1;
    wr_en = 1; wr_addr = 6'd9; wr_data = 64'h9999; wr_mask = 8'hFF;
    wr_commit = 1;
    cyc();
    idle();
    chk("simul rd_data", rd_data, 64'h7777);
    chk("simul rd_valid", 64'(rd_valid), 64'd1);
    chk("simul bank_full", 64'(bank_full), 64'b10);
    chk("simul wr_ready", 64'(wr_ready), 64'd1);
    chk("simul rd_ready", 64'(rd_ready), 64'd1);
    rd(6'd9);
    chk("simul bank1 data", rd_data, 64'h9999);
    chk("sticky err_rd_empty", 64'(err_rd_empty), 64'd1);

    // reset mid-fill of bank0
    wr_en = 1; wr_addr = 6'd1; wr_data = 64'h1111; wr_mask = 8'hFF;
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    idle();
    chk("mid rst bank_full", 64'(bank_full), 64'd0);
    chk("mid rst rd_ready", 64'(rd_ready), 64'd0);
    chk("mid rst wr_ready", 64'(wr_ready), 64'd1);
    chk("mid rst errs", 64'({err_wr_drop, err_rd_empty}), 64'd0);

    // memory survives reset: bank1 addr9 still holds its value
    commit();
    commit();
    release_bank();
    rd(6'd9);
    chk("post rst mem", rd_data, 64'h9999);
    cyc();

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
